iiq_scheduler: RTL and testbench

- Control and wakeup/select logic for the integer issue queue (IIQ).
- Tracks per-entry valid bits, source tags and source-ready bits; snoops wakeup broadcasts; selects the oldest ready entry each cycle and hands its index to execute.
- Queue is age-ordered and compacting: entry 0 is the oldest.
- The companion payload shift queue is driven from issue_idx/issue fire and compacts identically; this block never touches payload data.

---
 rtl/iiq_scheduler_pkg.sv | 23 ++
 rtl/iiq_prio_select.sv | 33 +++
 rtl/iiq_scheduler.sv | 147 ++++++++++++++
 tb/tb_iiq_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/iiq_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// global_defs
// Shared definitions for the integer issue queue scheduler and its siblings.
//   IIQ_N_ENTRIES : issue queue depth (power of two, >= 2)
//   TAG_WIDTH     : physical/ROB tag width of a source operand
//   IIQ_N_WAKEUP  : wakeup broadcast ports per cycle
//   iiq_sched_entry_t : per-entry scheduler state (valid, tags, ready bits)
// ---------------------------------------------------------------------------
package global_defs;

    localparam int IIQ_N_ENTRIES = 8;
    localparam int TAG_WIDTH     = 6;
    localparam int IIQ_N_WAKEUP  = 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] src1_tag;
        logic                 src1_rdy;
        logic [TAG_WIDTH-1:0] src2_tag;
        logic                 src2_rdy;
    } iiq_sched_entry_t;

endpackage : global_defs

// File: rtl/iiq_prio_select.sv
// ---------------------------------------------------------------------------
// iiq_prio_select
// N-input lowest-index priority encoder.
//   i_req   : request vector, bit 0 has the highest priority
//   o_grant : one-hot grant of the lowest set request (all zero if none)
//   o_idx   : binary index of the granted request (0 if none)
//   o_any   : at least one request is set
// ---------------------------------------------------------------------------
module iiq_prio_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Linear scan from index 0; w_found masks every request above the first hit.
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = i_req[i] & ~w_found;
            o_idx      = (i_req[i] && !w_found) ? IDX_W'(i) : o_idx;
            w_found    = w_found | i_req[i];
        end
        o_any = w_found;
    end

endmodule : iiq_prio_select

// File: rtl/iiq_scheduler.sv
// ---------------------------------------------------------------------------
// iiq_scheduler
// Wakeup/select control for the age-ordered, compacting integer issue queue.
// Entry 0 is the oldest; valid entries always occupy slots 0..count-1.
// The payload shift queue follows o_issue_idx / fire and compacts identically.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_flush               : squash all entries at the next edge
//   i_enq_*, o_enq_ready  : dispatch handshake and source operand info
//   i_wakeup_valid/tag    : per-port tag broadcasts, port k at [k*TAG_WIDTH +: TAG_WIDTH]
//   o_issue_valid/idx     : oldest fully-ready entry, i_issue_ready accepts it
//   o_count               : number of valid entries
// ---------------------------------------------------------------------------
module iiq_scheduler #(
    parameter int N_ENTRIES = global_defs::IIQ_N_ENTRIES,
    parameter int TAG_WIDTH = global_defs::TAG_WIDTH,
    parameter int N_WAKEUP  = global_defs::IIQ_N_WAKEUP,
    parameter int IDX_WIDTH = $clog2(N_ENTRIES)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_enq_valid,
    output logic                          o_enq_ready,
    input  logic [TAG_WIDTH-1:0]          i_enq_src1_tag,
    input  logic                          i_enq_src1_rdy,
    input  logic [TAG_WIDTH-1:0]          i_enq_src2_tag,
    input  logic                          i_enq_src2_rdy,
    input  logic [N_WAKEUP-1:0]           i_wakeup_valid,
    input  logic [N_WAKEUP*TAG_WIDTH-1:0] i_wakeup_tag,
    output logic                          o_issue_valid,
    input  logic                          i_issue_ready,
    output logic [IDX_WIDTH-1:0]          o_issue_idx,
    output logic [IDX_WIDTH:0]            o_count
);

    import global_defs::iiq_sched_entry_t;

    localparam int                CNT_W  = IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(N_ENTRIES);

    // True when any valid wakeup port broadcasts the given tag.
    function automatic logic f_wake_hit(
        input logic [N_WAKEUP-1:0]           vld,
        input logic [N_WAKEUP*TAG_WIDTH-1:0] tags,
        input logic [TAG_WIDTH-1:0]          tag
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_WAKEUP; k++) begin
            hit = hit | (vld[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag));
        end
        return hit;
    endfunction

    iiq_sched_entry_t r_entry [N_ENTRIES];
    logic [CNT_W-1:0] r_count;

    iiq_sched_entry_t w_up    [N_ENTRIES];
    iiq_sched_entry_t w_shift [N_ENTRIES];
    iiq_sched_entry_t w_wr    [N_ENTRIES];
    iiq_sched_entry_t w_next  [N_ENTRIES];
    iiq_sched_entry_t w_new;

    logic [N_ENTRIES-1:0] w_cand;
    logic [N_ENTRIES-1:0] w_grant;
    logic [IDX_WIDTH-1:0] w_sel_idx;
    logic                 w_sel_any;
    logic                 w_fire;
    logic                 w_enq;
    logic [CNT_W-1:0]     w_enq_slot;
    logic [CNT_W-1:0]     w_count_next;

    // Candidate vector from registered state only.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_cand[i] = r_entry[i].valid & r_entry[i].src1_rdy & r_entry[i].src2_rdy;
        end
    end

    iiq_prio_select #(
        .N     (N_ENTRIES),
        .IDX_W (IDX_WIDTH)
    ) u_select (
        .i_req   (w_cand),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_sel_any)
    );

    // Handshake outputs; rst and flush suppress issue in the same cycle.
    always_comb begin
        o_issue_valid = w_sel_any & ~i_rst & ~i_flush;
        o_issue_idx   = i_rst ? '0 : w_sel_idx;
        o_enq_ready   = ~i_rst & (r_count < C_FULL);
        o_count       = r_count;
        w_fire        = o_issue_valid & i_issue_ready;
        w_enq         = i_enq_valid & o_enq_ready;
        // A same-cycle fire frees one slot below the tail.
        w_enq_slot    = w_fire ? (r_count - CNT_W'(1)) : r_count;
        w_count_next  = r_count + CNT_W'(w_enq) - CNT_W'(w_fire);
    end

    // Incoming entry as dispatched, before same-cycle wakeup.
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.src1_tag = i_enq_src1_tag;
        w_new.src1_rdy = i_enq_src1_rdy;
        w_new.src2_tag = i_enq_src2_tag;
        w_new.src2_rdy = i_enq_src2_rdy;
    end

    // Next entry state: compact over the fired slot, insert, then apply wakeup
    // so shifted and freshly written entries both see this cycle's broadcasts.
    always_comb begin
        for (int i = 0; i < N_ENTRIES - 1; i++) begin
            w_up[i] = r_entry[i+1];
        end
        w_up[N_ENTRIES-1] = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_shift[i] = (w_fire && (IDX_WIDTH'(i) >= w_sel_idx)) ? w_up[i] : r_entry[i];
            w_wr[i]    = (w_enq && (CNT_W'(i) == w_enq_slot)) ? w_new : w_shift[i];
            w_next[i]  = w_wr[i];
            w_next[i].src1_rdy = w_wr[i].src1_rdy
                               | f_wake_hit(i_wakeup_valid, i_wakeup_tag, w_wr[i].src1_tag);
            w_next[i].src2_rdy = w_wr[i].src2_rdy
                               | f_wake_hit(i_wakeup_valid, i_wakeup_tag, w_wr[i].src2_tag);
        end
    end

    // State registers; reset beats flush beats normal update.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entry[i] <= w_next[i];
            end
            r_count <= w_count_next;
        end
    end

endmodule : iiq_scheduler

// File: tb/tb_iiq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_iiq_scheduler
// Scoreboard bench: the driver computes expected outputs from a queue-based
// reference model and pushes them; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_iiq_scheduler;

    localparam int N  = 8;
    localparam int TW = 6;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            enq_valid = 1'b0;
    logic            enq_ready;
    logic [TW-1:0]   s1_tag = '0;
    logic            s1_rdy = 1'b0;
    logic [TW-1:0]   s2_tag = '0;
    logic            s2_rdy = 1'b0;
    logic [NW-1:0]   wk_valid = '0;
    logic [NW*TW-1:0] wk_tag = '0;
    logic            issue_valid;
    logic            issue_ready = 1'b0;
    logic [2:0]      issue_idx;
    logic [3:0]      count;

    iiq_scheduler dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_enq_valid    (enq_valid),
        .o_enq_ready    (enq_ready),
        .i_enq_src1_tag (s1_tag),
        .i_enq_src1_rdy (s1_rdy),
        .i_enq_src2_tag (s2_tag),
        .i_enq_src2_rdy (s2_rdy),
        .i_wakeup_valid (wk_valid),
        .i_wakeup_tag   (wk_tag),
        .o_issue_valid  (issue_valid),
        .i_issue_ready  (issue_ready),
        .o_issue_idx    (issue_idx),
        .o_count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] t1;
        bit            r1;
        logic [TW-1:0] t2;
        bit            r2;
    } ent_t;

    typedef struct {
        bit         iv;
        logic [2:0] idx;
        bit         er;
        logic [3:0] cnt;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("issue_valid", int'(issue_valid), int'(e.iv));
            chk("issue_idx",   int'(issue_idx),   int'(e.idx));
            chk("enq_ready",   int'(enq_ready),   int'(e.er));
            chk("count",       int'(count),       int'(e.cnt));
        end
    end

    // One clock of stimulus: drive, predict outputs from the model, advance model.
    task automatic cycle(input bit r, input bit f, input bit ev,
                         input logic [TW-1:0] t1, input bit r1,
                         input logic [TW-1:0] t2, input bit r2,
                         input logic [NW-1:0] wv, input logic [NW*TW-1:0] wt,
                         input bit ir);
        exp_t e;
        int   sel;
        bit   fire;
        ent_t ne;
        @(posedge clk);
        #1;
        rst = r; flush = f; enq_valid = ev;
        s1_tag = t1; s1_rdy = r1; s2_tag = t2; s2_rdy = r2;
        wk_valid = wv; wk_tag = wt; issue_ready = ir;

        sel = -1;
        for (int j = 0; j < mq.size(); j++) begin
            if (sel < 0 && mq[j].r1 && mq[j].r2) sel = j;
        end
        e.cnt = 4'(mq.size());
        e.er  = !r && (mq.size() < N);
        e.iv  = (sel >= 0) && !r && !f;
        e.idx = (r || sel < 0) ? 3'd0 : 3'(sel);
        exp_q.push_back(e);

        if (r || f) begin
            mq.delete();
        end else begin
            fire = e.iv && ir;
            if (fire) mq.delete(sel);
            if (ev && e.er) begin
                ne.t1 = t1; ne.r1 = r1; ne.t2 = t2; ne.r2 = r2;
                mq.push_back(ne);
            end
            for (int j = 0; j < mq.size(); j++) begin
                for (int k = 0; k < NW; k++) begin
                    if (wv[k] && wt[k*TW +: TW] == mq[j].t1) mq[j].r1 = 1'b1;
                    if (wv[k] && wt[k*TW +: TW] == mq[j].t2) mq[j].r2 = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input bit ir);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, ir);
    endtask

    task automatic enq(input logic [TW-1:0] t1, input bit r1,
                       input logic [TW-1:0] t2, input bit r2, input bit ir);
        cycle(1'b0, 1'b0, 1'b1, t1, r1, t2, r2, 2'b00, 12'd0, ir);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 2'b00, 12'd0, 1'b1);
        end
    endtask

    initial begin
        // Establish a defined state before the scoreboard starts.
        repeat (2) @(posedge clk);

        // Reset then fill with ready entries while execute stalls.
        do_reset(2);
        for (int i = 0; i < N; i++) enq(6'(40 + i), 1'b1, 6'(50 + i), 1'b1, 1'b0);
        enq(6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
        idle(1'b0);

        // Oldest-first select with a late wakeup of entry 0.
        do_reset(1);
        enq(6'd5, 1'b0, 6'd30, 1'b1, 1'b0);
        enq(6'd20, 1'b0, 6'd21, 1'b0, 1'b0);
        enq(6'd22, 1'b1, 6'd23, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, {6'd0, 6'd5}, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Fire of entry 1 with simultaneous enqueue; count stays 4.
        do_reset(1);
        enq(6'd10, 1'b0, 6'd11, 1'b1, 1'b0);
        enq(6'd12, 1'b1, 6'd13, 1'b1, 1'b0);
        enq(6'd14, 1'b0, 6'd15, 1'b1, 1'b0);
        enq(6'd16, 1'b1, 6'd17, 1'b0, 1'b0);
        enq(6'd18, 1'b1, 6'd19, 1'b1, 1'b1);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b11, {6'd14, 6'd17}, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Same-cycle wakeup applied to the enqueuing entry.
        do_reset(1);
        cycle(1'b0, 1'b0, 1'b1, 6'd9, 1'b0, 6'd33, 1'b1, 2'b10, {6'd9, 6'd0}, 1'b0);
        idle(1'b0);

        // Flush beats enqueue and issue.
        do_reset(1);
        for (int i = 0; i < 6; i++) enq(6'(i), 1'b1, 6'(i + 8), 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 2'b00, 12'd0, 1'b1);
        idle(1'b1);

        // Full back-pressure: fire at count 8 does not admit the enqueue.
        do_reset(1);
        for (int i = 0; i < N; i++) enq(6'(i), 1'b1, 6'(i), 1'b1, 1'b0);
        enq(6'd60, 1'b1, 6'd61, 1'b1, 1'b1);
        enq(6'd60, 1'b1, 6'd61, 1'b1, 1'b0);
        idle(1'b0);

        // Mid-operation reset.
        cycle(1'b1, 1'b0, 1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 2'b00, 12'd0, 1'b1);
        idle(1'b1);

        // Randomized traffic with narrow tag space to force wakeup hits.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7),
                  6'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4),
                  6'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4),
                  2'($urandom_range(0, 3)),
                  {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))},
                  ($urandom_range(0, 1) == 1));
        end
        idle(1'b0);

        // Every pushed expectation must have been consumed by the monitor.
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_iiq_scheduler
